wishbone_master: RTL and testbench

//  Upstream neighbour of the Wishbone block-RAM slave. Converts a single-outstanding

---
 rtl/wb_pkg.sv | 34 +++
 rtl/lsu_align.sv | 55 +++++
 rtl/wishbone_master.sv | 181 ++++++++++++++++++
 tb/tb_wishbone_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone load/store master.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package wb_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_e;

    // Byte-lane enables for an access of the given size at the given byte offset.
    // The illegal size 2'b11 selects no lanes.
    function automatic logic [NUM_LANES-1:0] sel_gen(input logic [1:0] size,
                                                    input logic [1:0] addr_lo);
        logic [NUM_LANES-1:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b0001 << addr_lo;
            SZ_HALF: sel = 4'b0011 << addr_lo;
            SZ_WORD: sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: SEL generation, store replication, load shift/extend, misalign detect.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the owning FSM decides when the results are used.
import wb_pkg::*;

module lsu_align #(
    parameter int DW = 32
) (
    input  logic [1:0]           req_size,
    input  logic [1:0]           req_addr_lo,
    input  logic [DW-1:0]        req_wdata,
    output logic [NUM_LANES-1:0] req_sel,
    output logic [DW-1:0]        req_wdata_lanes,
    output logic                 req_misalign,
    input  logic [1:0]           ld_size,
    input  logic [1:0]           ld_addr_lo,
    input  logic                 ld_unsigned,
    input  logic [DW-1:0]        ld_word,
    output logic [DW-1:0]        ld_data
);

    logic [DW-1:0] ld_shifted;

    assign req_sel = sel_gen(req_size, req_addr_lo);

    // Request side: replicate the operand onto every lane it may land in, and flag bad alignment.
    always_comb begin
        req_wdata_lanes = req_wdata;
        req_misalign    = 1'b0;
        case (req_size)
            SZ_BYTE: req_wdata_lanes = {(DW/8){req_wdata[7:0]}};
            SZ_HALF: begin
                req_wdata_lanes = {(DW/16){req_wdata[15:0]}};
                req_misalign    = req_addr_lo[0];
            end
            SZ_WORD: req_misalign = |req_addr_lo;
            default: req_misalign = 1'b1;
        endcase
    end

    assign ld_shifted = ld_word >> {ld_addr_lo, 3'b000};

    // Load side: right-justify the addressed lanes, then zero- or sign-extend to the bus width.
    always_comb begin
        ld_data = ld_shifted;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {{(DW-8){1'b0}}, ld_shifted[7:0]}
                                           : {{(DW-8){ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data = ld_unsigned ? {{(DW-16){1'b0}}, ld_shifted[15:0]}
                                           : {{(DW-16){ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/wishbone_master.sv
// Single-outstanding core load/store to Wishbone classic master; bus timeout under WB_MASTER_TIMEOUT_EN.
// Latency: req@N -> STB@N+1 -> ACK@K -> o_VALID@K+1; misaligned requests return o_ERR the next cycle.
// Backpressure: o_BUSY high while a cycle is in flight, i_REQ ignored then; CYC/STB held until ACK.
import wb_pkg::*;

module wishbone_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_REQ,
    input  logic                  i_WE,
    input  logic [1:0]            i_SIZE,
    input  logic                  i_UNSIGNED,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_WDATA,
    output logic                  o_BUSY,
    output logic                  o_VALID,
    output logic                  o_ERR,
    output logic [DATA_WIDTH-1:0] o_RDATA,
    output logic [ADDR_WIDTH-1:0] o_ADDR,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic                  o_WE,
    output logic [3:0]            o_SEL,
    output logic                  o_STB,
    output logic                  o_CYC,
    input  logic                  i_ACK,
    output logic                  o_TAGN,
    input  logic                  i_TAGN
);

    state_e                  state, state_nx;
    logic [1:0]              lat_size, size_nx;
    logic [1:0]              lat_alo, alo_nx;
    logic                    lat_uns, uns_nx;
    logic                    busy_nx, cyc_nx, valid_nx, err_nx, we_nx;
    logic [DATA_WIDTH-1:0]   rdata_nx, data_nx;
    logic [ADDR_WIDTH-1:0]   addr_nx;
    logic [3:0]              sel_nx;

    logic [NUM_LANES-1:0]    req_sel;
    logic [DATA_WIDTH-1:0]   req_wdata_lanes;
    logic                    req_misalign;
    logic [DATA_WIDTH-1:0]   ld_data;

    logic                    unused_tagn;
    assign unused_tagn = i_TAGN;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt, tmo_cnt_nx;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    lsu_align #(.DW(DATA_WIDTH)) u_align (
        .req_size        (i_SIZE),
        .req_addr_lo     (i_ADDR[1:0]),
        .req_wdata       (i_WDATA),
        .req_sel         (req_sel),
        .req_wdata_lanes (req_wdata_lanes),
        .req_misalign    (req_misalign),
        .ld_size         (lat_size),
        .ld_addr_lo      (lat_alo),
        .ld_unsigned     (lat_uns),
        .ld_word         (i_DATA),
        .ld_data         (ld_data)
    );

    // Next-state and next-output logic; pulses default low, bus fields hold unless a request is accepted.
    always_comb begin
        state_nx = state;
        busy_nx  = o_BUSY;
        cyc_nx   = o_CYC;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        rdata_nx = '0;
        addr_nx  = o_ADDR;
        data_nx  = o_DATA;
        sel_nx   = o_SEL;
        we_nx    = o_WE;
        size_nx  = lat_size;
        alo_nx   = lat_alo;
        uns_nx   = lat_uns;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_cnt_nx = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (i_REQ) begin
                    if (req_misalign) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx = BUS;
                        busy_nx  = 1'b1;
                        cyc_nx   = 1'b1;
                        addr_nx  = {i_ADDR[ADDR_WIDTH-1:2], 2'b00};
                        data_nx  = req_wdata_lanes;
                        sel_nx   = req_sel;
                        we_nx    = i_WE;
                        size_nx  = i_SIZE;
                        alo_nx   = i_ADDR[1:0];
                        uns_nx   = i_UNSIGNED;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_cnt_nx = '0;
`endif
                    end
                end
            end
            BUS: begin
                if (i_ACK) begin
                    state_nx = RESP;
                    busy_nx  = 1'b0;
                    cyc_nx   = 1'b0;
                    valid_nx = 1'b1;
                    rdata_nx = o_WE ? '0 : ld_data;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    cyc_nx   = 1'b0;
                    err_nx   = 1'b1;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
`endif
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs; synchronous reset clears everything, dropping CYC/STB mid-cycle.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state    <= IDLE;
            o_BUSY   <= 1'b0;
            o_VALID  <= 1'b0;
            o_ERR    <= 1'b0;
            o_RDATA  <= '0;
            o_ADDR   <= '0;
            o_DATA   <= '0;
            o_WE     <= 1'b0;
            o_SEL    <= '0;
            o_STB    <= 1'b0;
            o_CYC    <= 1'b0;
            o_TAGN   <= 1'b0;
            lat_size <= '0;
            lat_alo  <= '0;
            lat_uns  <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            state    <= state_nx;
            o_BUSY   <= busy_nx;
            o_VALID  <= valid_nx;
            o_ERR    <= err_nx;
            o_RDATA  <= rdata_nx;
            o_ADDR   <= addr_nx;
            o_DATA   <= data_nx;
            o_WE     <= we_nx;
            o_SEL    <= sel_nx;
            o_STB    <= cyc_nx;
            o_CYC    <= cyc_nx;
            o_TAGN   <= 1'b0;
            lat_size <= size_nx;
            lat_alo  <= alo_nx;
            lat_uns  <= uns_nx;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt  <= tmo_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed self-checking bench for wishbone_master acting as the bus slave itself.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// Timeout scenario runs only when WB_MASTER_TIMEOUT_EN is defined.
module tb_wishbone_master;

    localparam int TMO = 8;

    logic        clk, rst;
    logic        req, we, uns, ack, tagn_i;
    logic [1:0]  size;
    logic [31:0] addr, wdata, wb_dat_i;
    logic        busy, valid, err, wb_we, wb_stb, wb_cyc, tagn_o;
    logic [31:0] rdata, wb_adr, wb_dat_o;
    logic [3:0]  wb_sel;

    int checks = 0;
    int errors = 0;

    wishbone_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .i_CLK(clk), .i_RST(rst), .i_REQ(req), .i_WE(we), .i_SIZE(size),
        .i_UNSIGNED(uns), .i_ADDR(addr), .i_WDATA(wdata),
        .o_BUSY(busy), .o_VALID(valid), .o_ERR(err), .o_RDATA(rdata),
        .o_ADDR(wb_adr), .o_DATA(wb_dat_o), .i_DATA(wb_dat_i), .o_WE(wb_we),
        .o_SEL(wb_sel), .o_STB(wb_stb), .o_CYC(wb_cyc), .i_ACK(ack),
        .o_TAGN(tagn_o), .i_TAGN(tagn_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; on return the request has been sampled once.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        step();
        req = 1'b0;
    endtask

    // Acknowledge the current bus cycle with the given read data.
    task automatic do_ack(input logic [31:0] d);
        wb_dat_i = d;
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({busy, valid, err, wb_cyc, wb_stb, wb_we, tagn_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/valid/err/cyc/stb/we/tagn=%b expected 0000000",
                     {busy, valid, err, wb_cyc, wb_stb, wb_we, tagn_o});
        end
        checks++;
        if ({wb_sel, wb_adr, wb_dat_o, rdata} !== 100'b0) begin
            errors++;
            $display("FAIL reset_data: got sel=%b adr=%h dat=%h rdata=%h expected all zero",
                     wb_sel, wb_adr, wb_dat_o, rdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_word_store();
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({wb_cyc, wb_stb, busy, wb_we, wb_sel} !== 8'b1111_1111) begin
            errors++;
            $display("FAIL wstore_ctrl: got cyc/stb/busy/we/sel=%b expected 11111111",
                     {wb_cyc, wb_stb, busy, wb_we, wb_sel});
        end
        checks++;
        if (wb_adr !== 32'h10 || wb_dat_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wstore_bus: got adr=%h dat=%h expected 00000010 deadbeef", wb_adr, wb_dat_o);
        end
        do_ack(32'h0);
        checks++;
        if ({valid, err, busy, wb_cyc, wb_stb} !== 5'b10000 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL wstore_resp: got valid/err/busy/cyc/stb=%b rdata=%h expected 10000 0",
                     {valid, err, busy, wb_cyc, wb_stb}, rdata);
        end
        step();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL wstore_pulse: got valid=%b expected 0", valid);
        end
    endtask

    task automatic test_byte_load();
        logic [31:0] exp_r [2];
        exp_r[0] = 32'hFFFFFF80;
        exp_r[1] = 32'h00000080;
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 2'b00, i[0], 32'h13, 32'h0);
            checks++;
            if (wb_sel !== 4'b1000 || wb_we !== 1'b0 || wb_adr !== 32'h10) begin
                errors++;
                $display("FAIL bload_bus%0d: got sel=%b we=%b adr=%h expected 1000 0 00000010",
                         i, wb_sel, wb_we, wb_adr);
            end
            do_ack(32'h80FF_0000);
            checks++;
            if (valid !== 1'b1 || rdata !== exp_r[i]) begin
                errors++;
                $display("FAIL bload_data%0d: got valid=%b rdata=%h expected 1 %h",
                         i, valid, rdata, exp_r[i]);
            end
            step();
        end
    endtask

    task automatic test_half();
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_1234);
        checks++;
        if (wb_sel !== 4'b1100 || wb_dat_o !== 32'h12341234 || wb_adr !== 32'h20) begin
            errors++;
            $display("FAIL hstore_bus: got sel=%b dat=%h adr=%h expected 1100 12341234 00000020",
                     wb_sel, wb_dat_o, wb_adr);
        end
        do_ack(32'h0);
        step();
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        do_ack(32'h80FF_0000);
        checks++;
        if (valid !== 1'b1 || rdata !== 32'hFFFF80FF) begin
            errors++;
            $display("FAIL hload_data: got valid=%b rdata=%h expected 1 ffff80ff", valid, rdata);
        end
        step();
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00A5);
        checks++;
        if (wb_sel !== 4'b0010 || wb_dat_o !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bstore_bus: got sel=%b dat=%h expected 0010 a5a5a5a5", wb_sel, wb_dat_o);
        end
        do_ack(32'h0);
        step();
    endtask

    task automatic test_misalign();
        logic [1:0]  sz [2];
        logic [31:0] ad [2];
        sz[0] = 2'b10; ad[0] = 32'h21;
        sz[1] = 2'b11; ad[1] = 32'h20;
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, sz[i], 1'b0, ad[i], 32'h0);
            checks++;
            if ({err, valid, busy, wb_cyc, wb_stb} !== 5'b10000 || rdata !== 32'h0) begin
                errors++;
                $display("FAIL misalign%0d: got err/valid/busy/cyc/stb=%b rdata=%h expected 10000 0",
                         i, {err, valid, busy, wb_cyc, wb_stb}, rdata);
            end
            step();
            checks++;
            if ({err, busy, wb_cyc} !== 3'b000) begin
                errors++;
                $display("FAIL misalign_pulse%0d: got err/busy/cyc=%b expected 000",
                         i, {err, busy, wb_cyc});
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++;
        if ({valid, err, wb_cyc} !== 3'b000) begin
            errors++;
            $display("FAIL idle_ack: got valid/err/cyc=%b expected 000", {valid, err, wb_cyc});
        end
    endtask

    task automatic test_back_to_back();
        int stable;
        stable = 0;
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'h0;
        step();
        addr = 32'h80;
        for (int i = 0; i < 5; i++) begin
            if (wb_adr == 32'h40 && wb_stb && wb_cyc && busy && !valid) stable++;
            step();
        end
        checks++;
        if (stable != 5 || wb_adr !== 32'h40 || wb_stb !== 1'b1) begin
            errors++;
            $display("FAIL ack_wait_stable: got %0d stable cycles adr=%h stb=%b expected 5 00000040 1",
                     stable, wb_adr, wb_stb);
        end
        req = 1'b0;
        do_ack(32'h12345678);
        checks++;
        if (valid !== 1'b1 || rdata !== 32'h12345678 || busy !== 1'b0) begin
            errors++;
            $display("FAIL delayed_load: got valid=%b rdata=%h busy=%b expected 1 12345678 0",
                     valid, rdata, busy);
        end
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h44; wdata = 32'hCAFEF00D;
        step();
        checks++;
        if (wb_cyc !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got cyc=%b valid=%b expected 0 0", wb_cyc, valid);
        end
        step();
        req = 1'b0;
        checks++;
        if (wb_cyc !== 1'b1 || wb_adr !== 32'h44 || wb_dat_o !== 32'hCAFEF00D || wb_we !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got cyc=%b adr=%h dat=%h we=%b expected 1 00000044 cafef00d 1",
                     wb_cyc, wb_adr, wb_dat_o, wb_we);
        end
        do_ack(32'h0);
        step();
    endtask

    task automatic test_reset_mid_cycle();
        issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        checks++;
        if (wb_cyc !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_start: got cyc=%b expected 1", wb_cyc);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({wb_cyc, wb_stb, valid, err, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL rstmid_drop: got cyc/stb/valid/err/busy=%b expected 00000",
                     {wb_cyc, wb_stb, valid, err, busy});
        end
        step();
        checks++;
        if ({valid, err, wb_cyc} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_after: got valid/err/cyc=%b expected 000", {valid, err, wb_cyc});
        end
    endtask

    task automatic test_timeout();
        int stb_cycles;
        int err_seen;
        stb_cycles = 0;
        err_seen = 0;
        issue(1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
        for (int i = 0; i < 20 && err_seen == 0; i++) begin
            if (wb_stb) stb_cycles++;
            if (err) err_seen = 1;
            else step();
        end
`ifdef WB_MASTER_TIMEOUT_EN
        checks++;
        if (err_seen != 1 || stb_cycles != TMO || wb_cyc !== 1'b0 || valid !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout: got err_seen=%0d stb_cycles=%0d cyc=%b valid=%b rdata=%h expected 1 %0d 0 0 0",
                     err_seen, stb_cycles, wb_cyc, valid, rdata, TMO);
        end
        step();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b busy=%b expected 0 0", err, busy);
        end
`else
        checks++;
        if (err_seen != 0 || stb_cycles != 20 || wb_cyc !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: got err_seen=%0d stb_cycles=%0d cyc=%b expected 0 20 1",
                     err_seen, stb_cycles, wb_cyc);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; uns = 1'b0; ack = 1'b0; tagn_i = 1'b1;
        size = 2'b00; addr = 32'h0; wdata = 32'h0; wb_dat_i = 32'h0;
        test_reset();
        test_word_store();
        test_byte_load();
        test_half();
        test_misalign();
        test_back_to_back();
        test_reset_mid_cycle();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
